// File: rtl/rv_pkg.sv
// Shared types and constants for the RV32IM instruction sequencer.
package rv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT,
    ST_TRAP
  } seq_state_t;

  typedef enum logic [1:0] {
    TRAP_ILLEGAL  = 2'd0,
    TRAP_MISALIGN = 2'd1,
    TRAP_TIMEOUT  = 2'd2,
    TRAP_FETCH    = 2'd3
  } trap_cause_t;

  localparam logic [31:0] INS_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INS_ZERO   = 32'h0000_0000;

  localparam int RD_LSB = 7;
  localparam int RD_MSB = 11;

endpackage

// File: rtl/rv_perf_counter.sv
// Free-running performance counter with enable and synchronous clear.
module rv_perf_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count up on enable and wrap naturally at 2**WIDTH; clear takes priority.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/rv_seq_ctrl.sv
// Multi-cycle instruction sequencer: owns the PC, fetches from a synchronous
// imem, hands each instruction to a variable-latency execute unit through a
// start/done handshake, gates write-back and reports halt/trap status.
// Optional performance counters are built when RV_SEQ_PERF_EN is defined.
module rv_seq_ctrl
  import rv_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              IMEM_AW    = 5,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              EX_TIMEOUT = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_run,
  output logic               o_imem_en,
  output logic [IMEM_AW-1:0] o_imem_addr,
  input  logic [31:0]        i_imem_rdata,
  output logic [31:0]        o_ins,
  output logic [XLEN-1:0]    o_pc,
  output logic               o_ex_start,
  input  logic               i_ex_done,
  input  logic               i_ex_redirect,
  input  logic [XLEN-1:0]    i_ex_target,
  input  logic               i_regwen_dec,
  output logic               o_regwen,
  output logic               o_retired,
  output logic               o_halted,
  output logic               o_trap,
  output logic [1:0]         o_trap_cause,
  output logic [31:0]        o_cycle_cnt,
  output logic [31:0]        o_instret_cnt
);

  localparam int              CNT_W    = $clog2(EX_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EX_TIMEOUT - 1);

  seq_state_t       r_state;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_target;
  logic [31:0]      r_ins;
  logic             r_redirect;
  logic             r_exStart;
  logic             r_regwen;
  logic             r_retired;
  logic             r_halted;
  logic             r_trap;
  trap_cause_t      r_trapCause;
  logic [CNT_W-1:0] r_waitCnt;

  logic w_pcInRange;
  logic w_doneMisaligned;
  logic w_wbMisaligned;

  // A PC beyond the imem depth would silently alias, so fetch checks the high bits.
  assign w_pcInRange      = ((r_pc >> (IMEM_AW + 2)) == '0);
  assign w_doneMisaligned = i_ex_redirect && (i_ex_target[1:0] != 2'b00);
  assign w_wbMisaligned   = r_redirect && (r_target[1:0] != 2'b00);

  // Sequencer FSM: every status output is a register updated on the transition.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_pc        <= RESET_PC;
      r_target    <= '0;
      r_ins       <= '0;
      r_redirect  <= 1'b0;
      r_exStart   <= 1'b0;
      r_regwen    <= 1'b0;
      r_retired   <= 1'b0;
      r_halted    <= 1'b0;
      r_trap      <= 1'b0;
      r_trapCause <= TRAP_ILLEGAL;
      r_waitCnt   <= '0;
    end else begin
      r_exStart <= 1'b0;
      r_regwen  <= 1'b0;
      r_retired <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_run) begin
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (!w_pcInRange) begin
            r_trap      <= 1'b1;
            r_trapCause <= TRAP_FETCH;
            r_state     <= ST_TRAP;
          end else begin
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          r_ins <= i_imem_rdata;
          if (i_imem_rdata == INS_EBREAK) begin
            r_halted <= 1'b1;
            r_state  <= ST_HALT;
          end else if (i_imem_rdata == INS_ZERO) begin
            r_trap      <= 1'b1;
            r_trapCause <= TRAP_ILLEGAL;
            r_state     <= ST_TRAP;
          end else begin
            r_exStart <= 1'b1;
            r_waitCnt <= '0;
            r_state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (i_ex_done) begin
            r_redirect <= i_ex_redirect;
            r_target   <= i_ex_target;
            r_state    <= ST_WB;
            if (!w_doneMisaligned) begin
              r_regwen  <= i_regwen_dec && (r_ins[RD_MSB:RD_LSB] != 5'd0);
              r_retired <= 1'b1;
            end
          end else if (r_waitCnt == CNT_LAST) begin
            r_trap      <= 1'b1;
            r_trapCause <= TRAP_TIMEOUT;
            r_state     <= ST_TRAP;
          end else begin
            r_waitCnt <= r_waitCnt + CNT_W'(1);
          end
        end
        ST_WB: begin
          if (w_wbMisaligned) begin
            r_trap      <= 1'b1;
            r_trapCause <= TRAP_MISALIGN;
            r_state     <= ST_TRAP;
          end else begin
            r_pc    <= r_redirect ? r_target : (r_pc + XLEN'(4));
            r_state <= i_run ? ST_FETCH : ST_IDLE;
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        ST_TRAP: begin
          r_state <= ST_TRAP;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_imem_en    = (r_state == ST_FETCH) && w_pcInRange;
  assign o_imem_addr  = r_pc[IMEM_AW+1:2];
  assign o_ins        = r_ins;
  assign o_pc         = r_pc;
  assign o_ex_start   = r_exStart;
  assign o_regwen     = r_regwen;
  assign o_retired    = r_retired;
  assign o_halted     = r_halted;
  assign o_trap       = r_trap;
  assign o_trap_cause = r_trapCause;

`ifdef RV_SEQ_PERF_EN
  logic w_countEn;

  assign w_countEn = (r_state != ST_HALT) && (r_state != ST_TRAP);

  rv_perf_counter #(.WIDTH(32)) u_cycleCnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (w_countEn),
    .i_clr   (1'b0),
    .o_count (o_cycle_cnt)
  );

  rv_perf_counter #(.WIDTH(32)) u_instretCnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (r_retired && w_countEn),
    .i_clr   (1'b0),
    .o_count (o_instret_cnt)
  );
`else
  assign o_cycle_cnt   = 32'd0;
  assign o_instret_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_rv_seq_ctrl.sv
// Directed bench for rv_seq_ctrl: a cycle table for a straight-line program
// ending in EBREAK, then hand-written sequences for latency, redirect,
// misalignment, fetch range, timeout, reset and run-gating corner cases.
module tb_rv_seq_ctrl;

  localparam logic [31:0] ADDI_X1 = 32'h0010_0093;
  localparam logic [31:0] ADDI_X2 = 32'h0020_0113;
  localparam logic [31:0] NOP_X0  = 32'h0000_0013;
  localparam logic [31:0] EBREAK  = 32'h0010_0073;

  logic        clk;
  logic        rst;
  logic        run;
  logic        imemEn;
  logic [4:0]  imemAddr;
  logic [31:0] imemRdata;
  logic [31:0] ins;
  logic [31:0] pc;
  logic        exStart;
  logic        exDone;
  logic        exRedirect;
  logic [31:0] exTarget;
  logic        regwenDec;
  logic        regwen;
  logic        retired;
  logic        halted;
  logic        trap;
  logic [1:0]  trapCause;
  logic [31:0] cycleCnt;
  logic [31:0] instretCnt;

  logic [31:0] mem [32];

  int  exLat;
  bit  exNever;
  bit  exBusy;
  int  exCnt;

  int checks;
  int errors;
  int nStart;
  int nRegwen;
  int nRet;
  int nImemEn;

  typedef struct {
    logic        run;
    logic [31:0] expPc;
    logic        expImemEn;
    logic        expExStart;
    logic        expRegwen;
    logic        expRetired;
    logic        expHalted;
  } vec_t;

  vec_t vecs [18];

  rv_seq_ctrl dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_run         (run),
    .o_imem_en     (imemEn),
    .o_imem_addr   (imemAddr),
    .i_imem_rdata  (imemRdata),
    .o_ins         (ins),
    .o_pc          (pc),
    .o_ex_start    (exStart),
    .i_ex_done     (exDone),
    .i_ex_redirect (exRedirect),
    .i_ex_target   (exTarget),
    .i_regwen_dec  (regwenDec),
    .o_regwen      (regwen),
    .o_retired     (retired),
    .o_halted      (halted),
    .o_trap        (trap),
    .o_trap_cause  (trapCause),
    .o_cycle_cnt   (cycleCnt),
    .o_instret_cnt (instretCnt)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (imemEn) begin
      imemRdata <= mem[imemAddr];
    end
  end

  // Execute-unit model: done arrives exLat cycles after the start pulse.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exBusy <= 1'b0;
      exCnt  <= 0;
    end else if (exStart && !exDone) begin
      exBusy <= 1'b1;
      exCnt  <= 1;
    end else if (exBusy && exDone) begin
      exBusy <= 1'b0;
    end else if (exBusy) begin
      exCnt <= exCnt + 1;
    end
  end

  assign exDone = !exNever && ((exLat == 0 && exStart) || (exBusy && exCnt == exLat));

  // Hard stop in case something wedges the whole run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    nStart  += int'(exStart);
    nRegwen += int'(regwen);
    nRet    += int'(retired);
    nImemEn += int'(imemEn);
  endtask

  task automatic applyStimulus(input logic runVal);
    run = runVal;
    stepCycle();
  endtask

  task automatic clearCounts();
    nStart  = 0;
    nRegwen = 0;
    nRet    = 0;
    nImemEn = 0;
  endtask

  task automatic doReset(input int lat, input bit never, input logic redir, input logic [31:0] tgt);
    @(negedge clk);
    rst        = 1'b1;
    run        = 1'b0;
    exLat      = lat;
    exNever    = never;
    exRedirect = redir;
    exTarget   = tgt;
    regwenDec  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clearCounts();
  endtask

  task automatic waitSignal(input int sel, input int maxCycles, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < maxCycles && !seen; k++) begin
      stepCycle();
      case (sel)
        0:       seen = retired;
        1:       seen = exStart;
        default: seen = trap;
      endcase
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s actual=not seen required=seen within %0d cycles", name, maxCycles);
    end
  endtask

  initial begin
    logic [31:0] expInstret;
    logic [31:0] expCycles;
    int          snap;

    checks = 0;
    errors = 0;
    clearCounts();
    rst        = 1'b1;
    run        = 1'b0;
    exLat      = 0;
    exNever    = 1'b0;
    exRedirect = 1'b0;
    exTarget   = 32'h0;
    regwenDec  = 1'b1;

    for (int i = 0; i < 32; i++) mem[i] = ADDI_X1;
    mem[1] = ADDI_X2;
    mem[2] = NOP_X0;
    mem[3] = EBREAK;
    mem[4] = ADDI_X2;

    vecs[0]  = '{1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'h4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 32'h4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    $display("[TB] straight-line program table");
    doReset(0, 1'b0, 1'b0, 32'h0);
    checkOutput("reset.ins", ins, 32'h0);
    checkOutput("reset.trapCause", 32'(trapCause), 32'h0);
    for (int i = 0; i < 18; i++) begin
      checkOutput($sformatf("vec%0d.pc", i), pc, vecs[i].expPc);
      checkOutput($sformatf("vec%0d.imemEn", i), 32'(imemEn), 32'(vecs[i].expImemEn));
      checkOutput($sformatf("vec%0d.exStart", i), 32'(exStart), 32'(vecs[i].expExStart));
      checkOutput($sformatf("vec%0d.regwen", i), 32'(regwen), 32'(vecs[i].expRegwen));
      checkOutput($sformatf("vec%0d.retired", i), 32'(retired), 32'(vecs[i].expRetired));
      checkOutput($sformatf("vec%0d.halted", i), 32'(halted), 32'(vecs[i].expHalted));
      checkOutput($sformatf("vec%0d.trap", i), 32'(trap), 32'h0);
      applyStimulus(vecs[i].run);
    end
    checkOutput("halt.ins", ins, EBREAK);
`ifdef RV_SEQ_PERF_EN
    expInstret = 32'd3;
    expCycles  = 32'd15;
`else
    expInstret = 32'd0;
    expCycles  = 32'd0;
`endif
    checkOutput("perf.instret", instretCnt, expInstret);
    checkOutput("perf.cycles", cycleCnt, expCycles);

    $display("[TB] variable latency with run dropped during EXEC");
    doReset(5, 1'b0, 1'b0, 32'h0);
    run = 1'b1;
    waitSignal(1, 10, "lat5.exStart");
    run = 1'b0;
    waitSignal(0, 20, "lat5.retired");
    checkOutput("lat5.nStart", 32'(nStart), 32'd1);
    checkOutput("lat5.nRegwen", 32'(nRegwen), 32'd1);
    checkOutput("lat5.trap", 32'(trap), 32'h0);
    stepCycle();
    checkOutput("lat5.pcAfter", pc, 32'h4);
    snap = nImemEn;
    repeat (4) stepCycle();
    checkOutput("lat5.idleNoFetch", 32'(nImemEn - snap), 32'd0);

    $display("[TB] aligned redirect");
    doReset(0, 1'b0, 1'b1, 32'h10);
    run = 1'b1;
    waitSignal(0, 10, "redir.retired");
    stepCycle();
    checkOutput("redir.pc", pc, 32'h10);
    checkOutput("redir.imemEn", 32'(imemEn), 32'h1);
    checkOutput("redir.imemAddr", 32'(imemAddr), 32'h4);

    $display("[TB] misaligned redirect");
    doReset(0, 1'b0, 1'b1, 32'h12);
    run = 1'b1;
    waitSignal(2, 10, "misal.trap");
    checkOutput("misal.cause", 32'(trapCause), 32'h1);
    checkOutput("misal.nRegwen", 32'(nRegwen), 32'h0);
    checkOutput("misal.nRet", 32'(nRet), 32'h0);
    checkOutput("misal.pc", pc, 32'h0);

    $display("[TB] fetch out of range");
    doReset(0, 1'b0, 1'b1, 32'h80);
    run = 1'b1;
    waitSignal(0, 10, "range.retired");
    stepCycle();
    checkOutput("range.pc", pc, 32'h80);
    checkOutput("range.imemEn", 32'(imemEn), 32'h0);
    stepCycle();
    checkOutput("range.trap", 32'(trap), 32'h1);
    checkOutput("range.cause", 32'(trapCause), 32'h3);
    snap = nImemEn;
    repeat (3) stepCycle();
    checkOutput("range.sticky", 32'(trap), 32'h1);
    checkOutput("range.noFetch", 32'(nImemEn - snap), 32'd0);

    $display("[TB] execute timeout");
    doReset(0, 1'b1, 1'b0, 32'h0);
    run = 1'b1;
    waitSignal(1, 10, "tmo.exStart");
    repeat (63) stepCycle();
    checkOutput("tmo.cycle64", 32'(trap), 32'h0);
    stepCycle();
    checkOutput("tmo.trap", 32'(trap), 32'h1);
    checkOutput("tmo.cause", 32'(trapCause), 32'h2);
    checkOutput("tmo.nStart", 32'(nStart), 32'd1);

    $display("[TB] done on the last allowed EXEC cycle");
    doReset(63, 1'b0, 1'b0, 32'h0);
    run = 1'b1;
    waitSignal(1, 10, "last.exStart");
    repeat (64) stepCycle();
    checkOutput("last.retired", 32'(retired), 32'h1);
    checkOutput("last.trap", 32'(trap), 32'h0);

    $display("[TB] reset in EXEC");
    doReset(0, 1'b0, 1'b0, 32'h0);
    run = 1'b1;
    waitSignal(0, 10, "rst.firstRetired");
    exNever = 1'b1;
    waitSignal(1, 10, "rst.secondStart");
    checkOutput("rst.pcBefore", pc, 32'h4);
    rst = 1'b1;
    #2;
    checkOutput("rst.pc", pc, 32'h0);
    checkOutput("rst.exStart", 32'(exStart), 32'h0);
    @(negedge clk);
    rst     = 1'b0;
    run     = 1'b0;
    exNever = 1'b0;
    clearCounts();
    repeat (3) stepCycle();
    checkOutput("rst.idle", 32'(nImemEn), 32'd0);
    run = 1'b1;
    stepCycle();
    checkOutput("rst.refetchEn", 32'(imemEn), 32'h1);
    checkOutput("rst.refetchAddr", 32'(imemAddr), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
